// File: rtl/tug_playfield.sv
// -----------------------------------------------------------------------------
// tug_playfield
//   Tug-of-war playfield. Owns the whole row of lights, the light position,
//   per-player scores and the round/match state. Button press edges are
//   detected internally; a press moves the single lit position one step
//   toward the pressing player's side, and pushing it off an edge wins the
//   round. After a round win the row goes dark for HOLD_CYCLES cycles, then
//   play restarts from the centre. The match ends when a score saturates.
//
// Parameters
//   NUM_LIGHTS  : number of lights (odd, >= 3)
//   SCORE_W     : score counter width; match ends at 2**SCORE_W-1
//   HOLD_CYCLES : dark cycles after a round win (>= 1)
//
// Ports
//   clock       : system clock, all state updates on posedge
//   reset       : synchronous active-low reset
//   LeftButton  : synchronised left player level, rising edge = press
//   RightButton : synchronised right player level, rising edge = press
//   lights      : playfield LEDs, bit NUM_LIGHTS-1 leftmost, bit 0 rightmost
//   left_score  : rounds won by the left player
//   right_score : rounds won by the right player
//   left_win    : one-cycle pulse on a left round win
//   right_win   : one-cycle pulse on a right round win
//   game_over   : high while the match is finished
// -----------------------------------------------------------------------------
module tug_playfield #(
    parameter int unsigned NUM_LIGHTS  = 9,
    parameter int unsigned SCORE_W     = 3,
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  LeftButton,
    input  logic                  RightButton,
    output logic [NUM_LIGHTS-1:0] lights,
    output logic [SCORE_W-1:0]    left_score,
    output logic [SCORE_W-1:0]    right_score,
    output logic                  left_win,
    output logic                  right_win,
    output logic                  game_over
);

    localparam int unsigned POS_W  = $clog2(NUM_LIGHTS);
    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [POS_W-1:0]   POS_CENTER  = POS_W'((NUM_LIGHTS - 1) / 2);
    localparam logic [POS_W-1:0]   POS_LEFT    = POS_W'(NUM_LIGHTS - 1);
    localparam logic [POS_W-1:0]   POS_RIGHT   = POS_W'(0);
    localparam logic [HOLD_W-1:0]  HOLD_LAST   = HOLD_W'(HOLD_CYCLES - 1);
    // Score value one below saturation: a win from here ends the match.
    localparam logic [SCORE_W-1:0] SCORE_FINAL = SCORE_W'((1 << SCORE_W) - 2);

    typedef enum logic [1:0] {
        ST_PLAY = 2'b00,
        ST_HOLD = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t                state_r;
    logic [POS_W-1:0]      pos_r;
    logic [HOLD_W-1:0]     hold_cnt_r;
    logic [SCORE_W-1:0]    left_score_r;
    logic [SCORE_W-1:0]    right_score_r;
    logic                  left_prev_r;
    logic                  right_prev_r;
    logic [NUM_LIGHTS-1:0] lights_r;
    logic                  left_win_r;
    logic                  right_win_r;
    logic                  game_over_r;

    logic                  left_press_s;
    logic                  right_press_s;
    logic                  move_left_s;
    logic                  move_right_s;

    // One-hot light pattern for a given position.
    function automatic logic [NUM_LIGHTS-1:0] onehot_f(input logic [POS_W-1:0] p);
        onehot_f = {{(NUM_LIGHTS-1){1'b0}}, 1'b1} << p;
    endfunction

    // Press edge detection and move decode; simultaneous presses cancel.
    always_comb begin
        left_press_s  = LeftButton  & ~left_prev_r;
        right_press_s = RightButton & ~right_prev_r;
        move_left_s   = left_press_s  & ~right_press_s;
        move_right_s  = right_press_s & ~left_press_s;
    end

    // Round/match FSM with registered datapath and outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r       <= ST_PLAY;
            pos_r         <= POS_CENTER;
            hold_cnt_r    <= '0;
            left_score_r  <= '0;
            right_score_r <= '0;
            // Prev registers start high so a button held through reset
            // release is not seen as a press.
            left_prev_r   <= 1'b1;
            right_prev_r  <= 1'b1;
            lights_r      <= onehot_f(POS_CENTER);
            left_win_r    <= 1'b0;
            right_win_r   <= 1'b0;
            game_over_r   <= 1'b0;
        end else begin
            left_prev_r <= LeftButton;
            right_prev_r <= RightButton;
            left_win_r  <= 1'b0;
            right_win_r <= 1'b0;
            case (state_r)
                ST_PLAY: begin
                    if (move_right_s && (pos_r == POS_RIGHT)) begin
                        right_win_r   <= 1'b1;
                        right_score_r <= right_score_r + SCORE_W'(1);
                        if (right_score_r == SCORE_FINAL) begin
                            state_r     <= ST_DONE;
                            lights_r    <= onehot_f(POS_RIGHT);
                            game_over_r <= 1'b1;
                        end else begin
                            state_r    <= ST_HOLD;
                            hold_cnt_r <= '0;
                            lights_r   <= '0;
                        end
                    end else if (move_left_s && (pos_r == POS_LEFT)) begin
                        left_win_r   <= 1'b1;
                        left_score_r <= left_score_r + SCORE_W'(1);
                        if (left_score_r == SCORE_FINAL) begin
                            state_r     <= ST_DONE;
                            lights_r    <= onehot_f(POS_LEFT);
                            game_over_r <= 1'b1;
                        end else begin
                            state_r    <= ST_HOLD;
                            hold_cnt_r <= '0;
                            lights_r   <= '0;
                        end
                    end else if (move_right_s) begin
                        pos_r    <= pos_r - POS_W'(1);
                        lights_r <= onehot_f(pos_r - POS_W'(1));
                    end else if (move_left_s) begin
                        pos_r    <= pos_r + POS_W'(1);
                        lights_r <= onehot_f(pos_r + POS_W'(1));
                    end else begin
                        lights_r <= onehot_f(pos_r);
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt_r == HOLD_LAST) begin
                        state_r    <= ST_PLAY;
                        hold_cnt_r <= '0;
                        pos_r      <= POS_CENTER;
                        lights_r   <= onehot_f(POS_CENTER);
                    end else begin
                        hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
                        lights_r   <= '0;
                    end
                end
                ST_DONE: begin
                    // Winner's edge bit already latched in lights_r.
                    game_over_r <= 1'b1;
                end
                default: begin
                    state_r     <= ST_PLAY;
                    pos_r       <= POS_CENTER;
                    hold_cnt_r  <= '0;
                    lights_r    <= onehot_f(POS_CENTER);
                    game_over_r <= 1'b0;
                end
            endcase
        end
    end

    assign lights      = lights_r;
    assign left_score  = left_score_r;
    assign right_score = right_score_r;
    assign left_win    = left_win_r;
    assign right_win   = right_win_r;
    assign game_over   = game_over_r;

endmodule
